// File: rtl/ps2_key_display.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_display
// Description : Pops scan-code bytes from a PS/2 keyboard FIFO and decodes
//               make/break/E0 sequences. Tracks the held key, counts new
//               presses in BCD and drives hex 7-segment glyphs for the code
//               and the counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_display #(
    parameter int CNT_DIGITS       = 2,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit BLANK_ON_RELEASE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ready,
    input  logic [7:0]              data,
    input  logic                    overflow,
    output logic                    nextdata_n,
    output logic                    key_valid,
    output logic [7:0]              key_code,
    output logic                    key_ext,
    output logic [4*CNT_DIGITS-1:0] press_count,
    output logic                    ovf_sticky,
    output logic [15:0]             seg_code,
    output logic [8*CNT_DIGITS-1:0] seg_cnt
);

    localparam logic [7:0] C_BYTE_EXT   = 8'hE0;
    localparam logic [7:0] C_BYTE_BREAK = 8'hF0;
    localparam logic [7:0] C_BYTE_ERR0  = 8'h00;
    localparam logic [7:0] C_BYTE_ERR1  = 8'hFF;
    localparam logic [7:0] C_SEG_BLANK  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                  state_q,       state_d;
    logic [7:0]              byte_q,        byte_d;
    logic                    nextdata_n_q,  nextdata_n_d;
    logic                    key_valid_q,   key_valid_d;
    logic [7:0]              key_code_q,    key_code_d;
    logic                    key_ext_q,     key_ext_d;
    logic [4*CNT_DIGITS-1:0] press_count_q, press_count_d;
    logic                    ovf_sticky_q,  ovf_sticky_d;
    logic                    ext_pending_q, ext_pending_d;
    logic                    brk_pending_q, brk_pending_d;

    logic                    w_same_key;
    logic                    w_carry;
    logic [4*CNT_DIGITS-1:0] w_count_inc;

    // Incoming byte (with its E0 prefix state) names the key currently held
    assign w_same_key = key_valid_q &&
                        ({ext_pending_q, byte_q} == {key_ext_q, key_code_q});

    // BCD increment with ripple carry; all-nines wraps to all-zeros
    always_comb begin
        w_count_inc = press_count_q;
        w_carry     = 1'b1;
        for (int i = 0; i < CNT_DIGITS; i++) begin
            if (w_carry) begin
                if (press_count_q[4*i +: 4] == 4'd9) begin
                    w_count_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*i +: 4] = press_count_q[4*i +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    // Pop sequencer and scan-code decoder next-state logic
    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        nextdata_n_d  = nextdata_n_q;
        key_valid_d   = key_valid_q;
        key_code_d    = key_code_q;
        key_ext_d     = key_ext_q;
        press_count_d = press_count_q;
        ovf_sticky_d  = ovf_sticky_q | overflow;
        ext_pending_d = ext_pending_q;
        brk_pending_d = brk_pending_q;

        case (state_q)
            ST_IDLE: begin
                if (ready) begin
                    state_d      = ST_POP;
                    byte_d       = data;
                    nextdata_n_d = 1'b0;
                end
            end
            ST_POP: begin
                state_d      = ST_GAP;
                nextdata_n_d = 1'b1;
                if (byte_q == C_BYTE_EXT) begin
                    ext_pending_d = 1'b1;
                end else if (byte_q == C_BYTE_BREAK) begin
                    brk_pending_d = 1'b1;
                end else begin
                    // Any terminal byte (including error codes) ends the sequence
                    ext_pending_d = 1'b0;
                    brk_pending_d = 1'b0;
                    if ((byte_q != C_BYTE_ERR0) && (byte_q != C_BYTE_ERR1)) begin
                        if (!brk_pending_q) begin
                            // Typematic repeats of the held key are not new presses
                            if (!w_same_key) begin
                                key_code_d    = byte_q;
                                key_ext_d     = ext_pending_q;
                                key_valid_d   = 1'b1;
                                press_count_d = w_count_inc;
                            end
                        end else if (w_same_key) begin
                            key_valid_d = 1'b0;
                        end
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset also aborts a byte caught in the pop cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            byte_q        <= 8'h00;
            nextdata_n_q  <= 1'b1;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            press_count_q <= '0;
            ovf_sticky_q  <= 1'b0;
            ext_pending_q <= 1'b0;
            brk_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            nextdata_n_q  <= nextdata_n_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            press_count_q <= press_count_d;
            ovf_sticky_q  <= ovf_sticky_d;
            ext_pending_q <= ext_pending_d;
            brk_pending_q <= brk_pending_d;
        end
    end

    // Active-high hex glyph, bit order {a,b,c,d,e,f,g,dp}, dp never lit
    function automatic logic [7:0] hex_glyph(input logic [3:0] v);
        logic [7:0] g;
        case (v)
            4'h0: g = 8'hFC;
            4'h1: g = 8'h60;
            4'h2: g = 8'hDA;
            4'h3: g = 8'hF2;
            4'h4: g = 8'h66;
            4'h5: g = 8'hB6;
            4'h6: g = 8'hBE;
            4'h7: g = 8'hE0;
            4'h8: g = 8'hFE;
            4'h9: g = 8'hF6;
            4'hA: g = 8'hEE;
            4'hB: g = 8'h3E;
            4'hC: g = 8'h9C;
            4'hD: g = 8'h7A;
            4'hE: g = 8'h9E;
            default: g = 8'h8E;
        endcase
        return SEG_ACTIVE_LOW ? ~g : g;
    endfunction

    assign nextdata_n  = nextdata_n_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign press_count = press_count_q;
    assign ovf_sticky  = ovf_sticky_q;

    // Code display blanks on release only when configured to
    always_comb begin
        if (BLANK_ON_RELEASE && !key_valid_q) begin
            seg_code = {C_SEG_BLANK, C_SEG_BLANK};
        end else begin
            seg_code = {hex_glyph(key_code_q[7:4]), hex_glyph(key_code_q[3:0])};
        end
    end

    generate
        for (genvar gi = 0; gi < CNT_DIGITS; gi++) begin : g_cnt_digit
            assign seg_cnt[8*gi +: 8] = hex_glyph(press_count_q[4*gi +: 4]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_display
// Description : Self-checking bench for ps2_key_display against a
//               behavioural key/counter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_display;

    localparam int CNT_DIGITS = 2;
    localparam int CNT_MOD    = 100;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    ready = 1'b0;
    logic [7:0]              data = 8'h00;
    logic                    overflow = 1'b0;
    logic                    nextdata_n;
    logic                    key_valid;
    logic [7:0]              key_code;
    logic                    key_ext;
    logic [4*CNT_DIGITS-1:0] press_count;
    logic                    ovf_sticky;
    logic [15:0]             seg_code;
    logic [8*CNT_DIGITS-1:0] seg_cnt;

    int errors = 0;
    int checks = 0;
    int pop_cnt = 0;

    // model state
    logic       m_valid;
    logic [7:0] m_code;
    logic       m_ext;
    int         m_cnt;
    logic       m_ep;
    logic       m_bp;
    logic       m_ovf;

    ps2_key_display #(
        .CNT_DIGITS       (CNT_DIGITS),
        .SEG_ACTIVE_LOW   (1'b1),
        .BLANK_ON_RELEASE (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .data        (data),
        .overflow    (overflow),
        .nextdata_n  (nextdata_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .press_count (press_count),
        .ovf_sticky  (ovf_sticky),
        .seg_code    (seg_code),
        .seg_cnt     (seg_cnt)
    );

    always #5 clk = ~clk;

    // each low cycle of the pop strobe is one pop
    always @(negedge clk) if (nextdata_n === 1'b0) pop_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] glyph_lo(input int v);
        string      s;
        logic [7:0] g;
        case (v)
            0: s = "abcdef";  1: s = "bc";      2: s = "abdeg";   3: s = "abcdg";
            4: s = "bcfg";    5: s = "acdfg";   6: s = "acdefg";  7: s = "abc";
            8: s = "abcdefg"; 9: s = "abcdfg";  10: s = "abcefg"; 11: s = "cdefg";
            12: s = "adef";   13: s = "bcdeg";  14: s = "adefg";  default: s = "aefg";
        endcase
        g = 8'h00;
        for (int i = 0; i < s.len(); i++) begin
            int idx;
            idx = int'(s[i]) - 97;
            g[7 - idx] = 1'b1;
        end
        return ~g;
    endfunction

    function automatic logic [4*CNT_DIGITS-1:0] exp_bcd();
        logic [4*CNT_DIGITS-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < CNT_DIGITS; i++) begin
            r[4*i +: 4] = 4'((m_cnt / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_seg_code();
        if (!m_valid) return 16'hFFFF;
        return {glyph_lo(int'(m_code[7:4])), glyph_lo(int'(m_code[3:0]))};
    endfunction

    function automatic logic [8*CNT_DIGITS-1:0] exp_seg_cnt();
        logic [8*CNT_DIGITS-1:0] r;
        int p;
        p = 1;
        for (int i = 0; i < CNT_DIGITS; i++) begin
            r[8*i +: 8] = glyph_lo((m_cnt / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_code = 0; m_ext = 0; m_cnt = 0; m_ep = 0; m_bp = 0; m_ovf = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ep = 1;
        else if (b == 8'hF0) m_bp = 1;
        else begin
            if (b != 8'h00 && b != 8'hFF) begin
                if (!m_bp) begin
                    if (!m_valid || m_ext != m_ep || m_code != b) begin
                        m_code = b; m_ext = m_ep; m_valid = 1;
                        m_cnt = (m_cnt + 1) % CNT_MOD;
                    end
                end else if (m_valid && m_ext == m_ep && m_code == b) begin
                    m_valid = 0;
                end
            end
            m_ep = 0; m_bp = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1; ready = 0; overflow = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        ready = 1; data = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (nextdata_n !== 1'b0 && n < 20);
        if (n >= 20) begin
            errors++; checks++;
            $display("FAIL pop_timeout: byte %02h never popped (nextdata_n=%b, want 0)", b, nextdata_n);
        end
        ready = 0; data = 8'($urandom);
        repeat (3) @(negedge clk);
        model_byte(b);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (nextdata_n !== 1'b1) begin errors++; $display("FAIL rst_nextdata_n: got %b want 1", nextdata_n); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_key_valid: got %b want 0", key_valid); end
        checks++; if ({key_ext, key_code} !== 9'h000) begin errors++; $display("FAIL rst_key: got %h want 000", {key_ext, key_code}); end
        checks++; if (press_count !== 8'h00) begin errors++; $display("FAIL rst_count: got %h want 00", press_count); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf_sticky); end
        checks++; if (seg_code !== 16'hFFFF) begin errors++; $display("FAIL rst_seg_code: got %h want FFFF", seg_code); end
        checks++; if (seg_cnt !== 16'h0303) begin errors++; $display("FAIL rst_seg_cnt: got %h want 0303", seg_cnt); end
    endtask

    task automatic test_release();
        int p0;
        do_reset();
        p0 = pop_cnt;
        send_byte(8'h15);
        checks++;
        if ({key_valid, key_code, press_count} !== {1'b1, 8'h15, 8'h01}) begin
            errors++; $display("FAIL release_make: got v=%b code=%h cnt=%h want v=1 code=15 cnt=01", key_valid, key_code, press_count);
        end
        checks++;
        if (seg_code !== {glyph_lo(1), glyph_lo(5)}) begin
            errors++; $display("FAIL release_seg_make: got %h want %h", seg_code, {glyph_lo(1), glyph_lo(5)});
        end
        send_byte(8'hF0);
        send_byte(8'h15);
        checks++;
        if ({key_valid, key_code, press_count, seg_code} !== {1'b0, 8'h15, 8'h01, 16'hFFFF}) begin
            errors++; $display("FAIL release_break: got v=%b code=%h cnt=%h seg=%h want v=0 code=15 cnt=01 seg=FFFF", key_valid, key_code, press_count, seg_code);
        end
        checks++;
        if (pop_cnt - p0 !== 3) begin errors++; $display("FAIL release_pops: got %0d low cycles want 3", pop_cnt - p0); end
    endtask

    task automatic test_typematic();
        do_reset();
        repeat (3) send_byte(8'h1C);
        checks++;
        if ({key_valid, press_count} !== {1'b1, 8'h01}) begin
            errors++; $display("FAIL typematic_repeat: got v=%b cnt=%h want v=1 cnt=01", key_valid, press_count);
        end
        checks++;
        if (seg_code !== 16'h9F63) begin errors++; $display("FAIL typematic_seg: got %h want 9F63", seg_code); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++;
        if ({key_valid, press_count} !== {1'b0, 8'h01}) begin
            errors++; $display("FAIL typematic_break: got v=%b cnt=%h want v=0 cnt=01", key_valid, press_count);
        end
        send_byte(8'h1C);
        checks++;
        if ({key_valid, press_count, seg_cnt} !== {1'b1, 8'h02, glyph_lo(0), glyph_lo(2)}) begin
            errors++; $display("FAIL typematic_again: got v=%b cnt=%h seg_cnt=%h want v=1 cnt=02 seg_cnt=%h", key_valid, press_count, seg_cnt, {glyph_lo(0), glyph_lo(2)});
        end
    endtask

    task automatic test_ext();
        do_reset();
        send_byte(8'hE0); send_byte(8'h75);
        checks++;
        if ({key_valid, key_ext, key_code} !== {1'b1, 1'b1, 8'h75}) begin
            errors++; $display("FAIL ext_make: got v=%b ext=%b code=%h want v=1 ext=1 code=75", key_valid, key_ext, key_code);
        end
        send_byte(8'hF0); send_byte(8'h75);
        checks++;
        if (key_valid !== 1'b1) begin errors++; $display("FAIL ext_mismatch_break: got v=%b want 1", key_valid); end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        checks++;
        if ({key_valid, press_count} !== {1'b0, 8'h01}) begin
            errors++; $display("FAIL ext_break: got v=%b cnt=%h want v=0 cnt=01", key_valid, press_count);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] k;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            k = (i % 2 == 1) ? 8'h23 : 8'h15;
            send_byte(k);
            if (i == 98) begin
                checks++;
                if (press_count !== 8'h99) begin errors++; $display("FAIL wrap_99: got %h want 99", press_count); end
            end
            send_byte(8'hF0);
            send_byte(k);
        end
        checks++;
        if (press_count !== 8'h00 || press_count !== exp_bcd()) begin
            errors++; $display("FAIL wrap_00: got %h want 00", press_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] sent[$];
        int         pops[$];
        do_reset();
        q = '{8'h15, 8'hF0, 8'h15, 8'h23};
        sent = q;
        @(negedge clk);
        ready = 1; data = q[0];
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (nextdata_n === 1'b0) begin
                pops.push_back(c);
                if (q.size() != 0) void'(q.pop_front());
            end
            if (q.size() != 0) begin ready = 1; data = q[0]; end
            else ready = 0;
        end
        foreach (sent[i]) model_byte(sent[i]);
        checks++;
        if (pops.size() !== 4) begin errors++; $display("FAIL b2b_pop_count: got %0d want 4", pops.size()); end
        for (int i = 1; i < pops.size() && i < 4; i++) begin
            checks++;
            if (pops[i] - pops[i-1] !== 3) begin
                errors++; $display("FAIL b2b_spacing%0d: got %0d cycles want 3", i, pops[i] - pops[i-1]);
            end
        end
        checks++;
        if ({key_valid, key_code, press_count} !== {m_valid, m_code, exp_bcd()}) begin
            errors++; $display("FAIL b2b_state: got v=%b code=%h cnt=%h want v=%b code=%h cnt=%h", key_valid, key_code, press_count, m_valid, m_code, exp_bcd());
        end
    endtask

    task automatic test_overflow();
        checks++;
        if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b want 0", ovf_sticky); end
        @(negedge clk); overflow = 1;
        @(negedge clk); overflow = 0;
        m_ovf = 1;
        repeat (10) @(negedge clk);
        checks++;
        if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf_sticky); end
        send_byte(8'h2B);
        checks++;
        if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b want 1", ovf_sticky); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0, 1: b = 8'h15;
                2:    b = 8'h23;
                3:    b = 8'h1C;
                4:    b = 8'hE0;
                5, 6: b = 8'hF0;
                7:    b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
                default: b = 8'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clk); overflow = 1;
                @(negedge clk); overflow = 0;
                m_ovf = 1;
            end
            send_byte(b);
            checks++;
            if ({key_valid, key_ext, key_code, press_count, ovf_sticky, seg_code, seg_cnt} !==
                {m_valid, m_ext, m_code, exp_bcd(), m_ovf, exp_seg_code(), exp_seg_cnt()}) begin
                errors++;
                $display("FAIL random_%0d byte %02h: got v=%b e=%b c=%h n=%h o=%b sc=%h sn=%h want v=%b e=%b c=%h n=%h o=%b sc=%h sn=%h",
                         n, b, key_valid, key_ext, key_code, press_count, ovf_sticky, seg_code, seg_cnt,
                         m_valid, m_ext, m_code, exp_bcd(), m_ovf, exp_seg_code(), exp_seg_cnt());
            end
        end
    endtask

    task automatic test_reset_mid_pop();
        int p0;
        do_reset();
        send_byte(8'h15);
        @(negedge clk);
        ready = 1; data = 8'h23;
        @(negedge clk);
        checks++;
        if (nextdata_n !== 1'b0) begin errors++; $display("FAIL midpop_in_pop: nextdata_n got %b want 0", nextdata_n); end
        rst = 1; ready = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
        checks++;
        if ({nextdata_n, key_valid, key_code, press_count} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
            errors++; $display("FAIL midpop_abort: got nd=%b v=%b c=%h n=%h want nd=1 v=0 c=00 n=00", nextdata_n, key_valid, key_code, press_count);
        end
        p0 = pop_cnt;
        repeat (6) @(negedge clk);
        checks++;
        if (pop_cnt !== p0 || key_valid !== 1'b0 || press_count !== 8'h00) begin
            errors++; $display("FAIL midpop_after: got pops=%0d v=%b n=%h want pops=0 v=0 n=00", pop_cnt - p0, key_valid, press_count);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_release();
        test_typematic();
        test_ext();
        test_wrap();
        test_back_to_back();
        test_overflow();
        test_random();
        test_reset_mid_pop();
        test_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
